// File: rtl/lpc_pkg.sv
// ----------------------------------------------------------------------------
// lpc_pkg
// Shared definitions for the LPC I/O-cycle target:
//   - lpc_state_e : FSM phases of an LPC I/O cycle, as seen by the target
//   - CYC_IO_RD / CYC_IO_WR : CYCTYPE field values (LAD[3:1]) we decode
//   - SYNC_READY  : SYNC code returned when the target is ready
//   - LAD_START / LAD_ABORT : LAD codes qualified by LFRAME_n=0
// ----------------------------------------------------------------------------
package lpc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CYCTYPE,
        ADDR,
        WDATA,
        HTAR,
        SYNC,
        RDATA,
        TTAR
    } lpc_state_e;

    localparam logic [2:0] CYC_IO_RD  = 3'b000;
    localparam logic [2:0] CYC_IO_WR  = 3'b001;

    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] LAD_START  = 4'h0;
    localparam logic [3:0] LAD_ABORT  = 4'hF;

endpackage

// File: rtl/lpc_io_target.sv
// ----------------------------------------------------------------------------
// lpc_io_target
// LPC 1.1 I/O-cycle target in front of a 32-byte register file. Decodes host
// I/O reads/writes, strobes the file (Wr/Rd) on a window hit, and returns
// read data on LAD with SYNC and turnaround handling. All logic runs on the
// rising edge of LpcClock; PciReset is asynchronous, active-low.
//
// Optional feature: define LPC_POST80_EN to also claim I/O writes to 0x0080
// and latch the byte into PostCode (no Wr pulse for that write).
//
// Ports:
//   LpcClock  in   33 MHz LPC clock
//   PciReset  in   asynchronous active-low reset
//   LFRAME_n  in   LPC frame, active low
//   LAD_in    in   [3:0] LAD sampled from the pins
//   LAD_out   out  [3:0] LAD value driven by the target (registered)
//   LAD_oe    out  LAD output enable, 1 = target drives
//   Addr      out  [7:0] register offset, zero-padded window offset
//   Wr        out  one-cycle register write strobe
//   DataWr    out  [7:0] write data, valid while Wr=1
//   Rd        out  one-cycle read strobe (read-clear hooks)
//   RdData    in   [7:0] register file data at Addr (combinational)
//   PostCode  out  [7:0] last port-80 code (LPC_POST80_EN only)
// ----------------------------------------------------------------------------
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int          WIN_BITS  = 5
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LFRAME_n,
    input  logic [3:0] LAD_in,
    output logic [3:0] LAD_out,
    output logic       LAD_oe,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWr,
    output logic       Rd,
    input  logic [7:0] RdData
`ifdef LPC_POST80_EN
    ,
    output logic [7:0] PostCode
`endif
);

    lpc_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // nibble counter within a phase
    logic        is_wr_q, is_wr_d;
    logic        hit_q, hit_d;          // address falls in the register window
    logic        p80_q, p80_d;          // write to port 0x80 (optional feature)
    logic        oe_q, oe_d;
    logic [3:0]  out_q, out_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  dw_q, dw_d;
    logic        rd_q, rd_d;

    logic [11:0] sh_q, sh_d;            // first three address nibbles
    logic [7:0]  wdata_q, wdata_d;      // assembled write byte
    logic [7:0]  hold_q, hold_d;        // read byte captured on HTAR2

    logic [15:0] full_addr;
    logic        p80_match;
    logic        claim;                 // target participates in SYNC/TAR

    assign full_addr = {sh_q, LAD_in};
    assign claim     = hit_q | p80_q;

`ifdef LPC_POST80_EN
    logic [7:0] post_q, post_d;
    assign p80_match = (full_addr == 16'h0080);
    assign PostCode  = post_q;
`else
    assign p80_match = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        hit_d   = hit_q;
        p80_d   = p80_q;
        oe_d    = oe_q;
        out_d   = out_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        dw_d    = dw_q;
        rd_d    = 1'b0;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
`ifdef LPC_POST80_EN
        post_d  = post_q;
`endif

        if (!LFRAME_n) begin
            // Any framed cycle (START, abort or a foreign start code)
            // releases LAD and restarts decoding; only START proceeds.
            oe_d  = 1'b0;
            out_d = LAD_ABORT;
            cnt_d = 2'd0;
            hit_d = 1'b0;
            p80_d = 1'b0;
            state_d = (LAD_in == LAD_START) ? CYCTYPE : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                end

                CYCTYPE: begin
                    cnt_d = 2'd0;
                    if (LAD_in[3:1] == CYC_IO_RD) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR;
                    end else if (LAD_in[3:1] == CYC_IO_WR) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end

                ADDR: begin
                    sh_d  = {sh_q[7:0], LAD_in};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        hit_d = (full_addr[15:WIN_BITS] == BASE_ADDR[15:WIN_BITS]);
                        p80_d = is_wr_q & p80_match;
                        if (hit_d) begin
                            addr_d = 8'(full_addr[WIN_BITS-1:0]);
                        end
                        cnt_d   = 2'd0;
                        state_d = is_wr_q ? WDATA : HTAR;
                    end
                end

                WDATA: begin
                    if (cnt_q == 2'd0) begin
                        wdata_d[3:0] = LAD_in;
                        cnt_d        = 2'd1;
                    end else begin
                        wdata_d[7:4] = LAD_in;
                        cnt_d        = 2'd0;
                        state_d      = HTAR;
                    end
                end

                HTAR: begin
                    if (cnt_q == 2'd0) begin
                        // Rd is visible during HTAR2 so the file has settled
                        // RdData by the edge that captures it.
                        cnt_d = 2'd1;
                        rd_d  = ~is_wr_q & hit_q;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = SYNC;
                        hold_d  = RdData;
                        if (claim) begin
                            oe_d  = 1'b1;
                            out_d = SYNC_READY;
                        end
                        if (is_wr_q & hit_q) begin
                            wr_d = 1'b1;
                            dw_d = wdata_q;
                        end
`ifdef LPC_POST80_EN
                        if (p80_q) begin
                            post_d = wdata_q;
                        end
`endif
                    end
                end

                SYNC: begin
                    cnt_d = 2'd0;
                    if (is_wr_q) begin
                        state_d = TTAR;
                        if (claim) out_d = LAD_ABORT;
                    end else begin
                        state_d = RDATA;
                        if (claim) out_d = hold_q[3:0];
                    end
                end

                RDATA: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                        if (claim) out_d = hold_q[7:4];
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = TTAR;
                        if (claim) out_d = LAD_ABORT;
                    end
                end

                TTAR: begin
                    if (cnt_q == 2'd0) begin
                        cnt_d = 2'd1;
                        oe_d  = 1'b0;
                        out_d = LAD_ABORT;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            is_wr_q <= 1'b0;
            hit_q   <= 1'b0;
            p80_q   <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 4'hF;
            addr_q  <= 8'h00;
            wr_q    <= 1'b0;
            dw_q    <= 8'h00;
            rd_q    <= 1'b0;
`ifdef LPC_POST80_EN
            post_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            hit_q   <= hit_d;
            p80_q   <= p80_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            dw_q    <= dw_d;
            rd_q    <= rd_d;
`ifdef LPC_POST80_EN
            post_q  <= post_d;
`endif
        end
    end

    // Datapath holding registers carry no reset; they are always written
    // before being used within a cycle.
    always_ff @(posedge LpcClock) begin
        sh_q    <= sh_d;
        wdata_q <= wdata_d;
        hold_q  <= hold_d;
    end

    assign LAD_out = out_q;
    assign LAD_oe  = oe_q;
    assign Addr    = addr_q;
    assign Wr      = wr_q;
    assign DataWr  = dw_q;
    assign Rd      = rd_q;

endmodule
